// File: rtl/data_memory_controller_pkg.sv
// Shared types and constants for the data-memory controller: FSM state encoding,
// data/mask widths and the mask applied to outgoing memory requests.
package data_memory_controller_pkg;

    typedef enum logic [2:0] {
        DMC_IDLE  = 3'd0,
        DMC_REQ   = 3'd1,
        DMC_WAIT  = 3'd2,
        DMC_DONE  = 3'd3,
        DMC_FAULT = 3'd4
    } dmc_state_e;

    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // Loads never carry byte lanes to the memory side.
    function automatic logic [MASK_WIDTH-1:0] request_mask(input logic                  is_write,
                                                           input logic [MASK_WIDTH-1:0] mask);
        return is_write ? mask : '0;
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Request/response bus between the data-memory controller (master) and a
// variable-latency memory (slave).
interface data_memory_controller_if
    import data_memory_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_address;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [MASK_WIDTH-1:0] mem_req_wmask;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_rdata;
    logic                  mem_resp_error;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_address, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_error
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_address, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_error
    );

endinterface

// File: rtl/data_memory_controller_access_timeout_counter.sv
// Access timeout counter: cleared when a request is accepted, counts while the
// transaction is in flight, saturates instead of wrapping.
module data_memory_controller_access_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Fires in the last allowed cycle so the FSM lands in FAULT exactly
    // TIMEOUT_CYCLES cycles after entering REQ.
    assign terminal = enable && (count_reg == LAST);

endmodule

// File: rtl/data_memory_controller.sv
// Multi-cycle data-memory port: latches one core load/store, runs the request and
// response handshake to memory, and stalls the core until the access completes.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [ADDR_WIDTH-1:0] core_address,
    input  logic [DATA_WIDTH-1:0] core_write_data,
    input  logic [MASK_WIDTH-1:0] core_write_mask,
    output logic [DATA_WIDTH-1:0] core_read_data,
    output logic                  write_done,
    output logic                  stall,
    output logic                  access_fault,
    data_memory_controller_if.master mem
);
    dmc_state_e            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [MASK_WIDTH-1:0] wmask_reg;
    logic                  write_reg;

    logic core_req;
    logic accept;
    logic in_flight;
    logic timeout_hit;
    logic capture_load;
    logic addr_offset_unused;

    assign core_req     = core_read | core_write;
    assign accept       = (state_reg == DMC_IDLE) && core_req;
    assign in_flight    = (state_reg == DMC_REQ) || (state_reg == DMC_WAIT);
    assign capture_load = (state_reg == DMC_WAIT) && mem.mem_resp_valid &&
                          !mem.mem_resp_error && !write_reg;

    // Memory is word addressed; the byte offset is already folded into the mask.
    assign addr_offset_unused = ^core_address[1:0];

    data_memory_controller_access_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) access_timeout_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (in_flight),
        .terminal (timeout_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= DMC_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wmask_reg <= '0;
            write_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= {core_address[ADDR_WIDTH-1:2], 2'b00};
                write_reg <= core_write;
                wdata_reg <= core_write ? core_write_data : '0;
                wmask_reg <= request_mask(core_write, core_write_mask);
            end
            if (capture_load) begin
                rdata_reg <= mem.mem_resp_rdata;
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        stall             = 1'b0;
        write_done        = 1'b0;
        access_fault      = 1'b0;
        core_read_data    = '0;
        mem.mem_req_valid = 1'b0;
        case (state_reg)
            DMC_IDLE: begin
                // Gated by reset so every output is low while reset is held.
                stall = core_req & reset;
                if (core_req) begin
                    state_next = DMC_REQ;
                end
            end
            DMC_REQ: begin
                stall             = 1'b1;
                mem.mem_req_valid = 1'b1;
                if (timeout_hit) begin
                    state_next = DMC_FAULT;
                end else if (mem.mem_req_ready) begin
                    state_next = DMC_WAIT;
                end
            end
            DMC_WAIT: begin
                stall = 1'b1;
                // A response in the final cycle still beats the timeout.
                if (mem.mem_resp_valid) begin
                    state_next = mem.mem_resp_error ? DMC_FAULT : DMC_DONE;
                end else if (timeout_hit) begin
                    state_next = DMC_FAULT;
                end
            end
            DMC_DONE: begin
                core_read_data = write_reg ? '0 : rdata_reg;
                write_done     = write_reg;
                state_next     = DMC_IDLE;
            end
            DMC_FAULT: begin
                access_fault = 1'b1;
                state_next   = DMC_IDLE;
            end
            default: begin
                state_next = DMC_IDLE;
            end
        endcase
    end

    assign mem.mem_req_write   = write_reg;
    assign mem.mem_req_address = addr_reg;
    assign mem.mem_req_wdata   = wdata_reg;
    assign mem.mem_req_wmask   = wmask_reg;

endmodule
